// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer between instruction memory and decode.
// Issues sequential word fetches ahead of decode with a bounded number of
// requests in flight. Returned words are queued with their PCs and handed
// to decode one per cycle. A branch redirect flushes the queue, arranges
// for stale in-flight responses to be dropped, and restarts at the target.
//
// Optional build macro FETCH_BUF_PERF_EN adds three saturating
// performance counters: perf_empty_cycles, perf_discards, perf_redirects.
module fetch_prefetch_buffer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0] perf_empty_cycles,
  output logic [31:0] perf_discards,
  output logic [31:0] perf_redirects
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam cnt_t DEPTH_C   = cnt_t'(DEPTH);
  localparam cnt_t MAX_OUT_C = cnt_t'(MAX_OUTSTANDING);

  // Architectural state.
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_q, discard_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;

  entry_t      fifo_mem [DEPTH];
  entry_t      head;

  // Per-cycle control decisions.
  logic        has_room;
  logic        has_credit;
  logic        issue;
  logic        resp;
  logic        resp_drop;
  logic        fifo_push;
  logic        fifo_pop;
  logic [31:0] target_aligned;

  assign target_aligned = {redirect_target[31:2], 2'b00};

  // Issue gating: queued entries plus in-flight requests must fit the FIFO,
  // so every response that is kept always has a free slot waiting for it.
  // Reset also gates the request so nothing is issued while state is held.
  always_comb begin
    has_room   = ({1'b0, count_q} + {1'b0, outstanding_q}) < {1'b0, DEPTH_C};
    has_credit = outstanding_q < MAX_OUT_C;
    imem_req   = !rst && !redirect && has_room && has_credit;
    imem_addr  = fetch_pc_q;
    issue      = imem_req;
  end

  // Response classification: a response is only meaningful if a request is
  // tracked for it; it is dropped while stale ones are pending or when it
  // lands in the redirect cycle itself.
  always_comb begin
    resp      = imem_rvalid && (outstanding_q != '0);
    resp_drop = resp && (redirect || (discard_q != '0));
    fifo_push = resp && !resp_drop;
  end

  // Decode-side view of the FIFO head; zero whenever the FIFO is empty so
  // the outputs read as zero during and straight after reset.
  always_comb begin
    head      = fifo_mem[rd_ptr_q];
    out_valid = (count_q != '0) && !redirect;
    out_pc    = (count_q != '0) ? head.pc    : '0;
    out_instr = (count_q != '0) ? head.instr : '0;
    fifo_pop  = out_valid && !stall;
  end

  // Next-state computation; redirect overrides every other update.
  // NOTE: every signal gets a default at the top of a combinational block so
  // no path leaves it unassigned and synthesis cannot infer a latch.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + cnt_t'(issue) - cnt_t'(resp);

    if (redirect) begin
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still in flight after this cycle is stale.
      discard_d  = outstanding_q - cnt_t'(resp);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_drop) begin
        discard_d = discard_q - cnt_t'(1);
      end
      if (fifo_push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(fifo_push) - cnt_t'(fifo_pop);
    end
  end

  // Control state register with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; count_q marks which entries are
  // live, so resetting the data would only cost area and routing.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_rdata};
    end
  end

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_empty_cycles_q, perf_empty_cycles_d;
  logic [31:0] perf_discards_q, perf_discards_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  // Saturating event counters; only reset clears them.
  always_comb begin
    perf_empty_cycles_d = perf_empty_cycles_q;
    perf_discards_d     = perf_discards_q;
    perf_redirects_d    = perf_redirects_q;
    if ((count_q == '0) && !redirect && (perf_empty_cycles_q != '1)) begin
      perf_empty_cycles_d = perf_empty_cycles_q + 32'd1;
    end
    if (resp_drop && (perf_discards_q != '1)) begin
      perf_discards_d = perf_discards_q + 32'd1;
    end
    if (redirect && (perf_redirects_q != '1)) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_empty_cycles_q <= '0;
      perf_discards_q     <= '0;
      perf_redirects_q    <= '0;
    end else begin
      perf_empty_cycles_q <= perf_empty_cycles_d;
      perf_discards_q     <= perf_discards_d;
      perf_redirects_q    <= perf_redirects_d;
    end
  end

  assign perf_empty_cycles = perf_empty_cycles_q;
  assign perf_discards     = perf_discards_q;
  assign perf_redirects    = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed testbench for fetch_prefetch_buffer with a behavioural
// instruction memory of configurable latency returning addr ^ 32'hA5A5_0000.
module tb_fetch_prefetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_empty_cycles;
  logic [31:0] perf_discards;
  logic [31:0] perf_redirects;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .stall(stall),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instr(out_instr)
`ifdef FETCH_BUF_PERF_EN
    ,
    .perf_empty_cycles(perf_empty_cycles),
    .perf_discards(perf_discards),
    .perf_redirects(perf_redirects)
`endif
  );

  // Memory model: samples the request late in each cycle, answers in order
  // exactly mem_lat cycles later. Reset clears everything pending.
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  int          cyc = 0;

  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_rvalid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + mem_lat);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (!rst && mq_addr.size() > 0 && mq_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq_addr[0] ^ XOR_K;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // The FIFO must never be pushed while full.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      assert (!(dut.fifo_push && dut.count_q == 3'(DEPTH)))
      else begin
        errors++;
        $display("FAIL fifo_overflow: push with count=%0d, required count<%0d", dut.count_q, DEPTH);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset(input int lat);
    @(negedge clk);
    rst      = 1'b1;
    redirect = 1'b0;
    stall    = 1'b0;
    mem_lat  = lat;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Reset values, then streaming with 1-cycle memory.
  task automatic test_reset_and_stream();
    @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h required 0", out_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
`ifdef FETCH_BUF_PERF_EN
    checks++; if (perf_empty_cycles !== 32'h0) begin errors++; $display("FAIL rst_perf_empty: got %0d required 0", perf_empty_cycles); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req c%0d: got %b required 1", j, imem_req); end
      checks++; if (imem_addr !== 32'(4 * j)) begin errors++; $display("FAIL stream_addr c%0d: got %h required %h", j, imem_addr, 32'(4 * j)); end
      if (j < 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency c%0d: valid %b required 0", j, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b required 1", j, out_valid); end
        checks++; if (out_pc !== 32'(4 * (j - 2))) begin errors++; $display("FAIL stream_pc c%0d: got %h required %h", j, out_pc, 32'(4 * (j - 2))); end
        checks++; if (out_instr !== (32'(4 * (j - 2)) ^ XOR_K)) begin errors++; $display("FAIL stream_instr c%0d: got %h required %h", j, out_instr, 32'(4 * (j - 2)) ^ XOR_K); end
      end
`ifdef FETCH_BUF_PERF_EN
      if (j == 2 || j == 9) begin
        checks++; if (perf_empty_cycles !== 32'd2) begin errors++; $display("FAIL perf_empty c%0d: got %0d required 2", j, perf_empty_cycles); end
      end
`endif
    end
  endtask

  // Stall for 10 cycles with head PC 32: FIFO fills to exactly 4 entries.
  task automatic test_stall();
    @(negedge clk);
    #1;
    checks++; if (out_pc !== 32'd32) begin errors++; $display("FAIL stall_start_pc: got %h required 20", out_pc); end
    checks++; if (imem_addr !== 32'd40) begin errors++; $display("FAIL stall_start_addr: got %h required 28", imem_addr); end
    stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid k%0d: got %b required 1", k, out_valid); end
      checks++; if (out_pc !== 32'd32) begin errors++; $display("FAIL stall_hold_pc k%0d: got %h required 20", k, out_pc); end
      checks++; if (out_instr !== (32'd32 ^ XOR_K)) begin errors++; $display("FAIL stall_hold_instr k%0d: got %h required %h", k, out_instr, 32'd32 ^ XOR_K); end
      checks++; if (imem_req !== (k < 2)) begin errors++; $display("FAIL stall_req k%0d: got %b required %b", k, imem_req, (k < 2)); end
      if (k >= 2) begin
        checks++; if (imem_addr !== 32'd48) begin errors++; $display("FAIL stall_addr k%0d: got %h required 30", k, imem_addr); end
      end
    end
    stall = 1'b0;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_valid m%0d: got %b required 1", m, out_valid); end
      checks++; if (out_pc !== 32'(36 + 4 * m)) begin errors++; $display("FAIL release_pc m%0d: got %h required %h", m, out_pc, 32'(36 + 4 * m)); end
    end
  endtask

  // 3-cycle memory, redirect to 0x103 with two requests in flight.
  task automatic test_redirect_discard();
    apply_reset(3);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL disc_addr0: got %h required 0", imem_addr); end
    @(negedge clk); #1;
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL disc_addr1: got %h/%b required 4/1", imem_addr, imem_req); end
    @(negedge clk);
    redirect        = 1'b1;
    redirect_target = 32'h0000_0103;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL disc_redir_req: got %b required 0", imem_req); end
    for (int c = 3; c <= 9; c++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      if (c <= 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL disc_stale_valid c%0d: got %b required 0", c, out_valid); end
      end
      if (c == 3 || c == 6) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL disc_credit c%0d: got %b required 0", c, imem_req); end
      end
      if (c == 4) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL disc_restart: got %b/%h required 1/100", imem_req, imem_addr); end
      end
      if (c == 8) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL disc_first_pc: got %b/%h required 1/100", out_valid, out_pc); end
        checks++; if (out_instr !== 32'hA5A5_0100) begin errors++; $display("FAIL disc_first_instr: got %h required a5a50100", out_instr); end
`ifdef FETCH_BUF_PERF_EN
        checks++; if (perf_discards !== 32'd2) begin errors++; $display("FAIL perf_discards_a: got %0d required 2", perf_discards); end
        checks++; if (perf_redirects !== 32'd1) begin errors++; $display("FAIL perf_redirects_a: got %0d required 1", perf_redirects); end
`endif
      end
      if (c == 9) begin
        checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL disc_second_pc: got %h required 104", out_pc); end
      end
    end
  endtask

  // Redirect in a cycle that also has a response and a would-be pop.
  task automatic test_redirect_collision();
    apply_reset(1);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin errors++; $display("FAIL coll_pre: got %b/%h required 1/8", out_valid, out_pc); end
    redirect        = 1'b1;
    redirect_target = 32'h0000_0200;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL coll_redir: valid/req %b/%b required 0/0", out_valid, imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_flushed: valid %b required 0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL coll_restart: got %b/%h required 1/200", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_no_push: valid %b required 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== 32'hA5A5_0200) begin errors++; $display("FAIL coll_first: got %b/%h/%h required 1/200/a5a50200", out_valid, out_pc, out_instr); end
`ifdef FETCH_BUF_PERF_EN
    checks++; if (perf_discards !== 32'd1 || perf_redirects !== 32'd1) begin errors++; $display("FAIL perf_coll: discards/redirects %0d/%0d required 1/1", perf_discards, perf_redirects); end
`endif
  endtask

  // Two consecutive redirect cycles: the second target wins.
  task automatic test_back_to_back();
    @(negedge clk);
    #1;
    checks++; if (out_pc !== 32'h204) begin errors++; $display("FAIL b2b_pre: got %h required 204", out_pc); end
    redirect        = 1'b1;
    redirect_target = 32'h0000_0300;
    @(negedge clk);
    redirect_target = 32'h0000_0404;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL b2b_second: valid/req %b/%b required 0/0", out_valid, imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin errors++; $display("FAIL b2b_restart: got %b/%h required 1/404", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: valid %b required 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h404) begin errors++; $display("FAIL b2b_first: got %b/%h required 1/404", out_valid, out_pc); end
`ifdef FETCH_BUF_PERF_EN
    checks++; if (perf_redirects !== 32'd3 || perf_discards !== 32'd2) begin errors++; $display("FAIL perf_b2b: redirects/discards %0d/%0d required 3/2", perf_redirects, perf_discards); end
`endif
  endtask

  // Redirect to an unaligned address near the top of the address space.
  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    logic [31:0] exp_out  [3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
    exp_out[0]  = 32'hFFFF_FFF8; exp_out[1]  = 32'hFFFF_FFFC; exp_out[2]  = 32'h0000_0000;
    @(negedge clk);
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFB;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir_valid: got %b required 0", out_valid); end
    for (int w = 1; w <= 5; w++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      if (w <= 3) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr[w-1]) begin errors++; $display("FAIL wrap_addr w%0d: got %b/%h required 1/%h", w, imem_req, imem_addr, exp_addr[w-1]); end
      end
      if (w >= 3) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== exp_out[w-3]) begin errors++; $display("FAIL wrap_pc w%0d: got %b/%h required 1/%h", w, out_valid, out_pc, exp_out[w-3]); end
        checks++; if (out_instr !== (exp_out[w-3] ^ XOR_K)) begin errors++; $display("FAIL wrap_instr w%0d: got %h required %h", w, out_instr, exp_out[w-3] ^ XOR_K); end
      end
    end
  endtask

  // Asynchronous reset with three entries queued.
  task automatic test_async_reset();
    @(negedge clk);
    #1;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL areset_pre: valid/req %b/%b required 1/0", out_valid, imem_req); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL areset_ctrl: valid/req %b/%b required 0/0", out_valid, imem_req); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL areset_data: pc/instr %h/%h required 0/0", out_pc, out_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL areset_addr: got %h required 0", imem_addr); end
`ifdef FETCH_BUF_PERF_EN
    checks++; if (perf_empty_cycles !== 32'h0 || perf_discards !== 32'h0 || perf_redirects !== 32'h0) begin errors++; $display("FAIL areset_perf: %0d/%0d/%0d required 0/0/0", perf_empty_cycles, perf_discards, perf_redirects); end
`endif
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset_first_fetch: got %b/%h required 1/0", imem_req, imem_addr); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== XOR_K) begin errors++; $display("FAIL areset_first_out: got %b/%h/%h required 1/0/a5a50000", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    rst             = 1'b1;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    stall           = 1'b0;
    test_reset_and_stream();
    test_stall();
    test_redirect_discard();
    test_redirect_collision();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
